// File: rtl/data_sync_src.sv
// data_sync_src: source side of a req/ack bus handshake (CLK, RST async low; src_data/src_valid/src_ready in; unsync_bus/bus_enable out; bus_ack in via NUM_STAGES sync; done_pulse out)
module data_sync_src #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] src_data,
  input  logic                 src_valid,
  output logic                 src_ready,
  output logic [BUS_WIDTH-1:0] unsync_bus,
  output logic                 bus_enable,
  input  logic                 bus_ack,
  output logic                 done_pulse
);
  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;
  state_t state, state_nxt;
  logic [NUM_STAGES-1:0] ack_sync;
  logic ack_s, accept, done_nxt;
  assign ack_s = ack_sync[NUM_STAGES-1];
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (src_valid ? REQ : IDLE) :
                state == REQ  ? (ack_s ? RELEASE : REQ) :
                                (ack_s ? RELEASE : IDLE);
  always_comb begin
    src_ready = state == IDLE;
    accept = src_ready && src_valid;
    done_nxt = state == RELEASE && !ack_s;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      ack_sync <= '0;
      unsync_bus <= '0;
      bus_enable <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      ack_sync <= {ack_sync[NUM_STAGES-2:0], bus_ack};
      if (accept) unsync_bus <= src_data;
      bus_enable <= state_nxt == REQ;
      done_pulse <= done_nxt;
    end
endmodule

// File: tb/tb_data_sync_src.sv
// tb_data_sync_src: directed and randomized checks of data_sync_src with a looped-back delayed acknowledge
module tb_data_sync_src;
  logic CLK = 1'b0, RST = 1'b1, src_valid = 1'b0;
  logic src_ready, bus_enable, bus_ack, done_pulse;
  logic [7:0] src_data = 8'h00, unsync_bus, u;
  logic force_en = 1'b1, force_val = 1'b0, prev_en = 1'b0;
  logic [15:0] hist = '0;
  int d = 3;
  int checks = 0, failures = 0, done_cnt = 0;
  int n, bad, base, rb, to, mism;
  logic [7:0] exp_q[$], rcv_q[$];
  data_sync_src #(.NUM_STAGES(2), .BUS_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .unsync_bus(unsync_bus), .bus_enable(bus_enable), .bus_ack(bus_ack), .done_pulse(done_pulse)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) hist <= {hist[14:0], bus_enable};
  always_comb bus_ack = force_en ? force_val : (d == 0 ? bus_enable : hist[d-1]);
  always @(posedge CLK) begin
    if (bus_enable && !prev_en) rcv_q.push_back(unsync_bus);
    if (done_pulse) done_cnt <= done_cnt + 1;
    prev_en <= bus_enable;
  end
  task automatic tick(int k = 1);
    repeat (k) begin
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_idle();
    int k = 0;
    while (!(src_ready && !bus_enable) && k < 200) begin
      tick();
      k++;
    end
    chk("idle_timeout", k < 200, 1);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    #1 RST = 1'b0;
    #1;
    chk("rst_ready", src_ready, 1);
    chk("rst_en", bus_enable, 0);
    chk("rst_bus", unsync_bus, 0);
    chk("rst_done", done_pulse, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    tick();
    force_en = 1'b0;
    d = 3;
    src_data = 8'hA5;
    src_valid = 1'b1;
    chk("acc_ready", src_ready, 1);
    tick();
    src_valid = 1'b0;
    chk("acc_bus", unsync_bus, 8'hA5);
    chk("acc_en", bus_enable, 1);
    chk("acc_ready_low", src_ready, 0);
    bad = 0;
    n = 0;
    while (bus_enable && n < 40) begin
      tick();
      n++;
      if (src_ready) bad++;
    end
    chk("rise_to_fall", n, 6);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (done_pulse) break;
      if (src_ready) bad++;
    end
    chk("fall_to_done", n, 6);
    chk("ready_low_during", bad, 0);
    chk("done_ready", src_ready, 1);
    tick();
    chk("done_width", done_pulse, 0);
    tick(8);
    d = 1;
    base = done_cnt;
    src_data = 8'h01;
    src_valid = 1'b1;
    tick();
    src_data = 8'h02;
    chk("b2b_first", unsync_bus, 8'h01);
    bad = 0;
    n = 0;
    while (!src_ready && n < 60) begin
      if (unsync_bus !== 8'h01) bad++;
      tick();
      n++;
    end
    chk("b2b_hold", bad, 0);
    chk("b2b_bus_at_ready", unsync_bus, 8'h01);
    chk("b2b_ready_ret", src_ready, 1);
    tick();
    src_valid = 1'b0;
    chk("b2b_second", unsync_bus, 8'h02);
    chk("b2b_en", bus_enable, 1);
    wait_idle();
    tick(2);
    chk("b2b_dones", done_cnt - base, 2);
    tick(8);
    force_en = 1'b1;
    force_val = 1'b0;
    src_data = 8'h3C;
    src_valid = 1'b1;
    tick();
    src_valid = 1'b0;
    src_data = 8'hFF;
    bad = 0;
    repeat (50) begin
      tick();
      if (!bus_enable || unsync_bus !== 8'h3C || src_ready) bad++;
    end
    chk("stall", bad, 0);
    chk("stall_en", bus_enable, 1);
    force_en = 1'b0;
    d = 2;
    wait_idle();
    tick(8);
    base = done_cnt;
    src_data = 8'h5A;
    src_valid = 1'b1;
    tick();
    src_valid = 1'b0;
    n = 0;
    while (bus_enable && n < 40) begin
      tick();
      n++;
    end
    chk("rel_reached", {bus_enable, src_ready}, 0);
    #2 RST = 1'b0;
    #1;
    chk("rel_rst_bus", unsync_bus, 0);
    chk("rel_rst_ready", src_ready, 1);
    chk("rel_rst_en", bus_enable, 0);
    tick(3);
    RST = 1'b1;
    tick(12);
    chk("rel_no_done", done_cnt - base, 0);
    force_en = 1'b1;
    force_val = 1'b0;
    src_data = 8'hC3;
    src_valid = 1'b1;
    tick();
    src_valid = 1'b0;
    tick(2);
    chk("req_en", bus_enable, 1);
    #2 RST = 1'b0;
    #1;
    chk("req_rst_en", bus_enable, 0);
    chk("req_rst_bus", unsync_bus, 0);
    src_data = 8'h77;
    src_valid = 1'b1;
    tick(2);
    @(negedge CLK);
    RST = 1'b1;
    tick();
    chk("post_rst_acc_en", bus_enable, 1);
    chk("post_rst_acc_bus", unsync_bus, 8'h77);
    src_valid = 1'b0;
    force_en = 1'b0;
    d = 2;
    wait_idle();
    tick(8);
    base = done_cnt;
    u = unsync_bus;
    force_en = 1'b1;
    force_val = 1'b1;
    bad = 0;
    repeat (4) begin
      tick();
      if (unsync_bus !== u || bus_enable || !src_ready || done_pulse) bad++;
    end
    force_val = 1'b0;
    repeat (6) begin
      tick();
      if (unsync_bus !== u || bus_enable || !src_ready || done_pulse) bad++;
    end
    chk("spurious", bad, 0);
    chk("spurious_done", done_cnt - base, 0);
    chk("spurious_bus", unsync_bus, 8'h77);
    force_en = 1'b0;
    rb = rcv_q.size();
    base = done_cnt;
    to = 0;
    for (int i = 0; i < 1000; i++) begin
      n = 0;
      while (!src_ready && n < 100) begin
        tick();
        n++;
      end
      if (n >= 100) to++;
      d = int'($urandom_range(0, 10));
      src_data = 8'($urandom);
      src_valid = 1'b1;
      tick();
      exp_q.push_back(src_data);
      if ($urandom_range(0, 3) == 0) begin
        src_valid = 1'b0;
        tick(int'($urandom_range(1, 3)));
      end
    end
    src_valid = 1'b0;
    wait_idle();
    tick(2);
    chk("rnd_timeouts", to, 0);
    chk("rnd_count", rcv_q.size() - rb, 1000);
    chk("rnd_dones", done_cnt - base, 1000);
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (rb + i >= rcv_q.size() || rcv_q[rb+i] !== exp_q[i]) mism++;
    chk("rnd_data", mism, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_sync_src.md
DATA_SYNC_SRC -- requirements
Module: data_sync_src

Interface
REQ-001 Parameter NUM_STAGES, default 2, SHALL set the number of flops in the acknowledge synchronizer (legal range 2 to 4).
REQ-002 Parameter BUS_WIDTH, default 8, SHALL set the data bus width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  source-domain clock; all state SHALL update on the rising edge.
REQ-005 RST  input  1  asynchronous active-low reset.
REQ-006 src_data  input  BUS_WIDTH  word to be transferred.
REQ-007 src_valid  input  1  the requester offers src_data.
REQ-008 src_ready  output  1  the block can accept a word this cycle.
REQ-009 unsync_bus  output  BUS_WIDTH  registered data driven toward the destination domain.
REQ-010 bus_enable  output  1  registered request level driven toward the destination domain.
REQ-011 bus_ack  input  1  acknowledge level from the destination domain; asynchronous to CLK.
REQ-012 done_pulse  output  1  one-cycle pulse when a transfer's handshake has fully completed.

Function
REQ-013 The FSM SHALL have three states: IDLE, REQ, RELEASE.
REQ-014 src_ready SHALL be combinational: 1 exactly when the state is IDLE.
REQ-015 Accept happens when the state is IDLE and src_valid=1. On the next edge:
- unsync_bus SHALL load src_data.
- bus_enable SHALL be set to 1.
- The state SHALL become REQ.
REQ-016 unsync_bus SHALL change only on an accept edge. It SHALL hold stable from the cycle bus_enable rises until the next accept.
REQ-017 bus_ack SHALL pass through a NUM_STAGES flop chain; the last stage is ack_s. The FSM SHALL use only ack_s.
REQ-018 In REQ, when ack_s=1: bus_enable SHALL clear to 0 on the next edge and the state SHALL become RELEASE. Otherwise the block SHALL stay in REQ indefinitely.
REQ-019 In RELEASE, when ack_s=0: done_pulse SHALL be 1 for exactly the next cycle and the state SHALL become IDLE. Otherwise the block SHALL stay in RELEASE.
REQ-020 Back-to-back transfers: src_valid held high in the cycle IDLE is re-entered SHALL be accepted in that cycle. The minimum spacing between bus_enable rising edges is therefore fixed by the handshake round trip.
REQ-021 src_valid and src_data SHALL be ignored outside IDLE. A requester SHALL hold src_valid until src_ready=1.
REQ-022 bus_enable SHALL be glitch-free: driven straight from a flop, with at most one rise and one fall per transfer.
REQ-023 Behaviour on an ack_s rise while in IDLE (protocol violation): ignored, with no state change and no done_pulse.
REQ-024 Behaviour on an ack_s drop while in REQ: no effect; the block keeps waiting for ack_s=1.
REQ-025 Latency, with ack asserted by the destination D cycles after seeing bus_enable: bus_enable falls NUM_STAGES+1+D cycles after it rises, measured at this block.

Reset
REQ-026 While RST=0, outputs SHALL be:
- state: IDLE
- unsync_bus: 0
- bus_enable: 0
- done_pulse: 0
- all synchronizer flops: 0
- src_ready: 1 after reset is applied
REQ-027 Reset asserted mid-transfer SHALL abort that transfer immediately, with no done_pulse. The destination sees bus_enable fall.
REQ-028 After reset release, the first edge with src_valid=1 SHALL be accepted.

Verification
REQ-029 Single transfer, NUM_STAGES=2, src_data=8'hA5 with src_valid for one cycle, bus_ack looped back through a 3-cycle delay:
- unsync_bus=8'hA5 and bus_enable=1 on the next edge.
- bus_enable falls 3+3 cycles after it rises.
- One done_pulse after ack falls.
- src_ready low throughout.
REQ-030 Back-to-back transfer, src_valid held with 8'h01 then 8'h02: two complete handshakes. unsync_bus changes to 8'h02 only on the cycle src_ready=1 returns.
REQ-031 Stalled acknowledge, bus_ack held 0 for 50 cycles: bus_enable stays 1, unsync_bus stays stable, and src_ready stays 0 for all 50 cycles.
REQ-032 Mid-transfer reset, RST pulsed low while in RELEASE: bus_enable=0, unsync_bus=0 and src_ready=1 asynchronously, and no done_pulse.
REQ-033 Spurious ack, bus_ack pulsed high for 4 cycles while IDLE with src_valid=0: no output changes and no done_pulse.
REQ-034 Random stimulus: 1000 transfers of random data with random ack delays of 0 to 10 cycles. The destination-side scoreboard SHALL receive an identical ordered sequence, with a done_pulse count equal to the accept count.
